// File: rtl/mem_pipe_arbiter.sv
// mem_pipe_arbiter: shares one single-port RAM as a FIFO between a writer and a reader.
// Define ARB_ROUND_ROBIN_EN to alternate the winner on conflicts; otherwise writes always win.
module mem_pipe_arbiter #(
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int MEM_DATA_WIDTH = 16
) (
    input  logic                      ti_clk,
    input  logic                      ti_rst_n,
    input  logic                      clear,
    input  logic                      wr_req,
    input  logic [MEM_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_gnt,
    input  logic                      rd_req,
    output logic                      rd_gnt,
    output logic                      rd_valid,
    output logic [MEM_DATA_WIDTH-1:0] rd_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
    output logic [MEM_ADDR_WIDTH:0]   count,
    output logic                      empty,
    output logic                      full
);
    logic [MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MEM_ADDR_WIDTH:0]   count_q, count_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      wr_elig, rd_elig;
`ifdef ARB_ROUND_ROBIN_EN
    logic                      last_winner_q, last_winner_d;
    logic                      conflict;
`endif

    // Count never exceeds the depth, so its top bit alone marks full
    assign empty     = count_q == '0;
    assign full      = count_q[MEM_ADDR_WIDTH];
    assign count     = count_q;
    assign mem_en    = wr_gnt | rd_gnt;
    assign mem_we    = wr_gnt;
    assign mem_addr  = wr_gnt ? wr_ptr_q : rd_ptr_q;
    assign mem_wdata = wr_data;
    assign rd_data   = mem_rdata;
    assign rd_valid  = rd_valid_q & ti_rst_n;

    // Eligibility, arbitration and next-state for pointers, count and read pipeline
    always_comb begin
        wr_elig = wr_req & ~full & ~clear & ti_rst_n;
        rd_elig = rd_req & ~empty & ~clear & ti_rst_n;
`ifdef ARB_ROUND_ROBIN_EN
        conflict      = wr_elig & rd_elig;
        wr_gnt        = wr_elig & ~(conflict & ~last_winner_q);
        rd_gnt        = rd_elig & ~(conflict & last_winner_q);
        last_winner_d = conflict ? ~last_winner_q : last_winner_q;
`else
        wr_gnt        = wr_elig;
        rd_gnt        = rd_elig & ~wr_elig;
`endif
        wr_ptr_d   = clear ? '0 : wr_ptr_q + MEM_ADDR_WIDTH'(wr_gnt);
        rd_ptr_d   = clear ? '0 : rd_ptr_q + MEM_ADDR_WIDTH'(rd_gnt);
        count_d    = clear ? '0 : count_q + (MEM_ADDR_WIDTH+1)'(wr_gnt) - (MEM_ADDR_WIDTH+1)'(rd_gnt);
        rd_valid_d = rd_gnt;
    end

    // State registers; reset takes precedence over clear
    always_ff @(posedge ti_clk) begin
        if (!ti_rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_valid_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_valid_q    <= rd_valid_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_pipe_arbiter.sv
// tb_mem_pipe_arbiter: randomized and directed checks against a queue-based FIFO model.
module tb_mem_pipe_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          ti_clk = 1'b0;
    logic          ti_rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, empty, full;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   count;

    mem_pipe_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
        .ti_clk(ti_clk), .ti_rst_n(ti_rst_n), .clear(clear),
        .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .count(count), .empty(empty), .full(full)
    );

    always #5 ti_clk = ~ti_clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge ti_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] fifo [$];
    int            wa = 0;
    int            ra = 0;
    bit            pend_v = 0;
    logic [DW-1:0] pend_d = '0;
    bit            rd_turn = 1;
    bit            dw, dr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit rn, input bit cl, input bit wq, input bit rq,
                       input logic [DW-1:0] wd, output bit wg, output bit rg);
        bit we, re, full_m, empty_m;
        ti_rst_n = rn; clear = cl; wr_req = wq; rd_req = rq; wr_data = wd;
        full_m  = fifo.size() == DEPTH;
        empty_m = fifo.size() == 0;
        we = rn && !cl && wq && !full_m;
        re = rn && !cl && rq && !empty_m;
        if (we && re) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (rd_turn) we = 0; else re = 0;
            rd_turn = !rd_turn;
`else
            re = 0;
`endif
        end
        @(negedge ti_clk);
        chk("wr_gnt", wr_gnt, we);
        chk("rd_gnt", rd_gnt, re);
        chk("mem_en", mem_en, we || re);
        chk("mem_we", mem_we, we);
        chk("count", count, fifo.size());
        chk("empty", empty, empty_m);
        chk("full", full, full_m);
        chk("rd_valid", rd_valid, pend_v && rn);
        if (pend_v && rn) chk("rd_data", rd_data, pend_d);
        if (we || re) chk("mem_addr", mem_addr, we ? wa : ra);
        if (we) chk("mem_wdata", mem_wdata, wd);
        @(posedge ti_clk);
        if (!rn || cl) begin
            fifo.delete(); wa = 0; ra = 0; pend_v = 0;
            if (!rn) rd_turn = 1;
        end else begin
            pend_v = re;
            if (we) begin fifo.push_back(wd); wa = (wa + 1) % DEPTH; end
            if (re) begin pend_d = fifo.pop_front(); ra = (ra + 1) % DEPTH; end
        end
        wg = we; rg = re;
        #1;
    endtask

    initial begin
        bit            rn, cl, wq, rq;
        logic [DW-1:0] wd;
        @(posedge ti_clk); #1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 16'h1234, dw, dr);
        for (int i = 1; i <= 10; i++) cyc(1, 0, 1, 0, DW'(i), dw, dr);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, i < 10, '0, dw, dr);
        cyc(0, 0, 0, 0, '0, dw, dr);
        for (int i = 1; i <= 16; i++) cyc(1, 0, 1, 0, i == 16 ? 16'h00AA : DW'(i), dw, dr);
        cyc(1, 0, 1, 0, 16'h00BB, dw, dr);
        cyc(1, 0, 1, 1, 16'h00BB, dw, dr);
        cyc(1, 0, 1, 0, 16'h00BB, dw, dr);
        cyc(1, 0, 0, 0, '0, dw, dr);
        cyc(0, 0, 0, 0, '0, dw, dr);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, DW'(16'h50 + i), dw, dr);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, DW'(16'h60 + i), dw, dr);
        cyc(0, 0, 0, 0, '0, dw, dr);
        cyc(1, 0, 1, 1, 16'hC0DE, dw, dr);
        cyc(1, 0, 0, 1, '0, dw, dr);
        cyc(1, 0, 0, 0, '0, dw, dr);
        cyc(0, 0, 0, 0, '0, dw, dr);
        for (int i = 0; i < 7; i++) cyc(1, 0, 1, 0, DW'(16'h70 + i), dw, dr);
        cyc(1, 1, 1, 1, 16'h0077, dw, dr);
        cyc(1, 0, 1, 0, 16'h0077, dw, dr);
        cyc(1, 0, 0, 1, '0, dw, dr);
        cyc(0, 0, 0, 1, '0, dw, dr);
        cyc(1, 0, 0, 0, '0, dw, dr);
        wq = 0; rq = 0; wd = '0;
        for (int i = 0; i < 400; i++) begin
            rn = $urandom_range(0, 49) != 0;
            cl = $urandom_range(0, 29) == 0;
            if (!wq) begin
                wq = $urandom_range(0, 2) != 0;
                wd = DW'($urandom);
            end
            if (!rq) rq = $urandom_range(0, 2) != 0;
            cyc(rn, cl, wq, rq, wd, dw, dr);
            if (dw) wq = 0;
            if (dr) rq = 0;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
